k051962_pixel_shifter: RTL and testbench

Serialises tile ROM fetches into a per-pixel stream for the 051962 tile layer. Accepts one 32-bit ROM word (eight 4-bit pixels) plus colour attribute per tile into a one-deep staging register, then emits one pixel per pixel-enable with horizontal flip and line-start fine-scroll skip. Sits between the ROM data latch and the selectable VC input delay chains, which consume `PIX_OUT`/`COL_OUT` directly.

---
 rtl/k051962_pkg.sv | 27 ++
 rtl/k051962_tile_stage.sv | 48 ++++
 rtl/k051962_pixel_shifter.sv | 134 +++++++++++++
 tb/tb_k051962_pixel_shifter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k051962_pkg.sv
// Shared constants, state encoding and pixel selection for the
// 051962 tile pixel shifter.
package k051962_pkg;

    localparam int PIX_W  = 4;
    localparam int NPIX   = 8;
    localparam int COL_W  = 8;
    localparam int IDX_W  = $clog2(NPIX);
    localparam int WORD_W = PIX_W * NPIX;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Emission-order index k to pixel code, honouring horizontal flip.
    function automatic logic [PIX_W-1:0] pix_sel(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  k,
        input logic              flip
    );
        logic [IDX_W-1:0] p;
        p = flip ? (IDX_W'(NPIX - 1) - k) : k;
        return word[PIX_W*p +: PIX_W];
    endfunction

endpackage

// File: rtl/k051962_tile_stage.sv
// One-deep staging register for tile ROM word, colour and flip,
// with sticky overwrite detection.
module k051962_tile_stage
    import k051962_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              line_start,
    input  logic              take,
    input  logic [WORD_W-1:0] rom_word,
    input  logic [COL_W-1:0]  rom_col,
    input  logic              rom_flip,
    output logic [WORD_W-1:0] word,
    output logic [COL_W-1:0]  col,
    output logic              flip,
    output logic              valid,
    output logic              ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            col   <= '0;
            flip  <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                word <= rom_word;
                col  <= rom_col;
                flip <= rom_flip;
            end
            // A line start flushes staging; a LOAD on that edge refills it.
            if (line_start) begin
                valid <= load;
            end else if (load) begin
                valid <= 1'b1;
                if (valid && !take) begin
                    ovf <= 1'b1;
                end
            end else if (take) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/k051962_pixel_shifter.sv
// Tile pixel serialiser: staging -> active tile -> one pixel per PE,
// with horizontal flip and first-tile fine-scroll skip.
module k051962_pixel_shifter
    import k051962_pkg::*;
(
    input  logic              CK,
    input  logic              RES,
    input  logic              PE,
    input  logic              LOAD,
    input  logic [WORD_W-1:0] ROM_D,
    input  logic [COL_W-1:0]  COL_IN,
    input  logic              FLIPX,
    input  logic              LINE_START,
    input  logic [IDX_W-1:0]  FINE,
    output logic [PIX_W-1:0]  PIX_OUT,
    output logic [COL_W-1:0]  COL_OUT,
    output logic              OPAQUE,
    output logic              VALID,
    output logic              PEND_OVF
);

    state_t            state, n_state;
    logic [IDX_W-1:0]  idx, n_idx;
    logic              first, n_first;
    logic [IDX_W-1:0]  fine_q, n_fine;
    logic [WORD_W-1:0] act_word, n_act_word;
    logic [COL_W-1:0]  act_col, n_act_col;
    logic              act_flip, n_act_flip;
    logic [PIX_W-1:0]  n_pix;
    logic [COL_W-1:0]  n_col;
    logic              n_opq;
    logic              n_vld;

    logic [WORD_W-1:0] stg_word;
    logic [COL_W-1:0]  stg_col;
    logic              stg_flip;
    logic              stg_valid;
    logic              take;
    logic              at_end;
    logic [IDX_W-1:0]  start;

    k051962_tile_stage u_stage (
        .clk        (CK),
        .rst_n      (RES),
        .load       (LOAD),
        .line_start (LINE_START),
        .take       (take),
        .rom_word   (ROM_D),
        .rom_col    (COL_IN),
        .rom_flip   (FLIPX),
        .word       (stg_word),
        .col        (stg_col),
        .flip       (stg_flip),
        .valid      (stg_valid),
        .ovf        (PEND_OVF)
    );

    always_comb begin
        n_state    = state;
        n_idx      = idx;
        n_first    = first;
        n_fine     = fine_q;
        n_act_word = act_word;
        n_act_col  = act_col;
        n_act_flip = act_flip;
        n_pix      = PIX_OUT;
        n_col      = COL_OUT;
        n_opq      = OPAQUE;
        n_vld      = VALID;
        take       = 1'b0;
        at_end     = (state == IDLE) || (idx == IDX_W'(NPIX - 1));
        start      = first ? fine_q : '0;

        if (LINE_START) begin
            n_state = IDLE;
            n_first = 1'b1;
            n_fine  = FINE;
            n_pix   = '0;
            n_opq   = 1'b0;
            n_vld   = 1'b0;
        end else if (PE && !at_end) begin
            n_idx = idx + 1'b1;
            n_pix = pix_sel(act_word, n_idx, act_flip);
            n_opq = |n_pix;
        end else if (PE && stg_valid) begin
            take       = 1'b1;
            n_act_word = stg_word;
            n_act_col  = stg_col;
            n_act_flip = stg_flip;
            n_idx      = start;
            n_pix      = pix_sel(stg_word, start, stg_flip);
            n_opq      = |n_pix;
            n_col      = stg_col;
            n_first    = 1'b0;
            n_state    = RUN;
            n_vld      = 1'b1;
        end else if (PE) begin
            // Underrun: go quiet but keep the last colour on the bus.
            n_state = IDLE;
            n_pix   = '0;
            n_opq   = 1'b0;
            n_vld   = 1'b0;
        end
    end

    always_ff @(posedge CK or negedge RES) begin
        if (!RES) begin
            state    <= IDLE;
            idx      <= '0;
            first    <= 1'b1;
            fine_q   <= '0;
            act_word <= '0;
            act_col  <= '0;
            act_flip <= 1'b0;
            PIX_OUT  <= '0;
            COL_OUT  <= '0;
            OPAQUE   <= 1'b0;
            VALID    <= 1'b0;
        end else begin
            state    <= n_state;
            idx      <= n_idx;
            first    <= n_first;
            fine_q   <= n_fine;
            act_word <= n_act_word;
            act_col  <= n_act_col;
            act_flip <= n_act_flip;
            PIX_OUT  <= n_pix;
            COL_OUT  <= n_col;
            OPAQUE   <= n_opq;
            VALID    <= n_vld;
        end
    end

endmodule

// File: tb/tb_k051962_pixel_shifter.sv
// Bench for k051962_pixel_shifter: directed scenarios plus random
// traffic against a queue-based pixel stream model.
module tb_k051962_pixel_shifter;

    logic        CK = 1'b0;
    logic        RES = 1'b0;
    logic        PE = 1'b0;
    logic        LOAD = 1'b0;
    logic [31:0] ROM_D = '0;
    logic [7:0]  COL_IN = '0;
    logic        FLIPX = 1'b0;
    logic        LINE_START = 1'b0;
    logic [2:0]  FINE = '0;
    logic [3:0]  PIX_OUT;
    logic [7:0]  COL_OUT;
    logic        OPAQUE;
    logic        VALID;
    logic        PEND_OVF;

    int total = 0;
    int bad = 0;

    k051962_pixel_shifter dut (
        .CK         (CK),
        .RES        (RES),
        .PE         (PE),
        .LOAD       (LOAD),
        .ROM_D      (ROM_D),
        .COL_IN     (COL_IN),
        .FLIPX      (FLIPX),
        .LINE_START (LINE_START),
        .FINE       (FINE),
        .PIX_OUT    (PIX_OUT),
        .COL_OUT    (COL_OUT),
        .OPAQUE     (OPAQUE),
        .VALID      (VALID),
        .PEND_OVF   (PEND_OVF)
    );

    always #5 CK = ~CK;

    // Reference model: staging slot plus a queue of pixels still to emit.
    logic [31:0] s_word;
    logic [7:0]  s_col;
    bit          s_flip, s_vld;
    bit          m_first, m_ovf;
    int          m_fine;
    logic [3:0]  rem[$];
    logic [3:0]  m_pix;
    logic [7:0]  m_col;
    bit          m_opq, m_vld;

    function automatic logic [3:0] nib(input logic [31:0] w, input int p);
        return w[4*p +: 4];
    endfunction

    task automatic model_reset();
        s_word = '0; s_col = '0; s_flip = 0; s_vld = 0;
        m_first = 1; m_ovf = 0; m_fine = 0;
        rem.delete();
        m_pix = '0; m_col = '0; m_opq = 0; m_vld = 0;
    endtask

    task automatic model_edge(input bit ls, input bit ld, input bit pe,
                              input logic [31:0] w, input logic [7:0] c,
                              input bit f, input int fn);
        bit took;
        int st;
        took = 0;
        if (ls) begin
            rem.delete();
            m_first = 1; m_fine = fn;
            m_pix = '0; m_opq = 0; m_vld = 0;
            s_vld = ld;
            if (ld) begin s_word = w; s_col = c; s_flip = f; end
        end else begin
            if (pe) begin
                if (rem.size() > 0) begin
                    m_pix = rem.pop_front();
                    m_opq = (m_pix != 0);
                end else if (s_vld) begin
                    st = m_first ? m_fine : 0;
                    for (int k = st; k < 8; k++)
                        rem.push_back(nib(s_word, s_flip ? 7 - k : k));
                    m_pix = rem.pop_front();
                    m_opq = (m_pix != 0);
                    m_col = s_col; m_vld = 1; m_first = 0; took = 1;
                end else begin
                    m_pix = '0; m_opq = 0; m_vld = 0;
                end
            end
            if (ld) begin
                if (s_vld && !took) m_ovf = 1;
                s_word = w; s_col = c; s_flip = f; s_vld = 1;
            end else if (took) begin
                s_vld = 0;
            end
        end
    endtask

    task automatic step(input bit ls, input bit ld, input bit pe,
                        input logic [31:0] w, input logic [7:0] c,
                        input bit f, input logic [2:0] fn);
        LINE_START = ls; LOAD = ld; PE = pe;
        ROM_D = w; COL_IN = c; FLIPX = f; FINE = fn;
        @(posedge CK);
        model_edge(ls, ld, pe, w, c, f, int'(fn));
        #1;
        LINE_START = 0; LOAD = 0; PE = 0;
    endtask

    task automatic do_reset();
        RES = 0;
        model_reset();
        @(posedge CK);
        #1;
        RES = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({PIX_OUT, COL_OUT, OPAQUE, VALID, PEND_OVF} !== 15'd0) begin
            bad++;
            $display("FAIL reset_state got=%0h want=0",
                     {PIX_OUT, COL_OUT, OPAQUE, VALID, PEND_OVF});
        end
        step(0, 1, 0, 32'h76543210, 8'h5C, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, '0, '0, 0, 0);
        total++;
        if (PIX_OUT !== 4'd3 || VALID !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_idx3 got=%0h/%0b want=3/1", PIX_OUT, VALID);
        end
        RES = 0;
        model_reset();
        #1;
        total++;
        if ({PIX_OUT, COL_OUT, OPAQUE, VALID, PEND_OVF} !== 15'd0) begin
            bad++;
            $display("FAIL mid_tile_reset got=%0h want=0",
                     {PIX_OUT, COL_OUT, OPAQUE, VALID, PEND_OVF});
        end
        @(posedge CK);
        #1;
        RES = 1;
        step(0, 1, 0, 32'h89ABCDEF, 8'h44, 0, 0);
        step(0, 0, 1, '0, '0, 0, 0);
        total++;
        if (PIX_OUT !== 4'hF || VALID !== 1'b1 || COL_OUT !== 8'h44) begin
            bad++;
            $display("FAIL after_reset_pix0 got=%0h/%0b/%0h want=f/1/44",
                     PIX_OUT, VALID, COL_OUT);
        end
    endtask

    task automatic test_order(input bit f);
        logic [3:0] want;
        do_reset();
        step(0, 1, 0, 32'h76543210, 8'h2A, f, 0);
        total++;
        if (VALID !== 1'b0) begin
            bad++;
            $display("FAIL no_bypass got=%0b want=0", VALID);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, '0, '0, 0, 0);
            want = f ? 4'(7 - i) : 4'(i);
            total++;
            if (PIX_OUT !== want || COL_OUT !== 8'h2A || VALID !== 1'b1
                || OPAQUE !== (want != 0)) begin
                bad++;
                $display("FAIL order_flip%0b_%0d got=%0h/%0h/%0b/%0b want=%0h/2a/1/%0b",
                         f, i, PIX_OUT, COL_OUT, VALID, OPAQUE, want, want != 0);
            end
        end
    endtask

    task automatic test_fine_underrun();
        logic [3:0] exp_seq[13];
        for (int i = 0; i < 5; i++) exp_seq[i] = 4'(3 + i);
        for (int i = 0; i < 8; i++) exp_seq[5 + i] = 4'(8 + i);
        do_reset();
        step(1, 0, 0, '0, '0, 0, 3'd3);
        step(0, 1, 0, 32'h76543210, 8'h11, 0, 0);
        for (int i = 0; i < 13; i++) begin
            if (i == 1) step(0, 1, 1, 32'hFEDCBA98, 8'h22, 0, 0);
            else        step(0, 0, 1, '0, '0, 0, 0);
            total++;
            if (PIX_OUT !== exp_seq[i] || VALID !== 1'b1) begin
                bad++;
                $display("FAIL fine_seq_%0d got=%0h/%0b want=%0h/1",
                         i, PIX_OUT, VALID, exp_seq[i]);
            end
        end
        step(0, 0, 1, '0, '0, 0, 0);
        total++;
        if (PIX_OUT !== 4'd0 || VALID !== 1'b0 || OPAQUE !== 1'b0
            || COL_OUT !== 8'h22) begin
            bad++;
            $display("FAIL underrun got=%0h/%0b/%0b/%0h want=0/0/0/22",
                     PIX_OUT, VALID, OPAQUE, COL_OUT);
        end
        step(0, 1, 0, 32'h0000000A, 8'h33, 0, 0);
        step(0, 0, 1, '0, '0, 0, 0);
        total++;
        if (PIX_OUT !== 4'hA || VALID !== 1'b1 || COL_OUT !== 8'h33) begin
            bad++;
            $display("FAIL late_load got=%0h/%0b/%0h want=a/1/33",
                     PIX_OUT, VALID, COL_OUT);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(0, 1, 0, 32'h11111111, 8'h01, 0, 0);
        step(0, 1, 0, 32'h22222222, 8'h02, 0, 0);
        total++;
        if (PEND_OVF !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got=%0b want=1", PEND_OVF);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, '0, '0, 0, 0);
            total++;
            if (PIX_OUT !== 4'd2) begin
                bad++;
                $display("FAIL ovf_newer_%0d got=%0h want=2", i, PIX_OUT);
            end
        end
        do_reset();
        step(0, 1, 0, 32'h33333333, 8'h03, 0, 0);
        step(0, 0, 1, '0, '0, 0, 0);
        step(0, 1, 0, 32'h44444444, 8'h04, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, '0, '0, 0, 0);
        step(0, 1, 1, 32'h55555555, 8'h05, 0, 0);
        total++;
        if (PEND_OVF !== 1'b0 || PIX_OUT !== 4'd4 || COL_OUT !== 8'h04) begin
            bad++;
            $display("FAIL load_on_xfer got=%0b/%0h/%0h want=0/4/04",
                     PEND_OVF, PIX_OUT, COL_OUT);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, '0, '0, 0, 0);
        total++;
        if (PEND_OVF !== 1'b0 || PIX_OUT !== 4'd5 || VALID !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back got=%0b/%0h/%0b want=0/5/1",
                     PEND_OVF, PIX_OUT, VALID);
        end
    endtask

    task automatic test_random();
        bit ls, ld, pe;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            ls = ($urandom_range(0, 59) == 0);
            ld = ($urandom_range(0, 5) == 0);
            pe = ($urandom_range(0, 1) == 0);
            step(ls, ld, pe, $urandom, 8'($urandom), 1'($urandom),
                 3'($urandom));
            total++;
            if (PIX_OUT !== m_pix || COL_OUT !== m_col || OPAQUE !== m_opq
                || VALID !== m_vld || PEND_OVF !== m_ovf) begin
                bad++;
                $display("FAIL rand_%0d got=%0h/%0h/%0b/%0b/%0b want=%0h/%0h/%0b/%0b/%0b",
                         n, PIX_OUT, COL_OUT, OPAQUE, VALID, PEND_OVF,
                         m_pix, m_col, m_opq, m_vld, m_ovf);
            end
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_order(0);
        test_order(1);
        test_fine_underrun();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
